fifo_ring_buffer: RTL
=====================

// Module: fifo_ring_buffer
// PURPOSE
//  Circular-buffer FIFO with valid/ready handshake on both sides. Parametrised successor to the
//  pipeline shift-register queue: fixed storage (no data shifting), first-word-fall-through output,
//  occupancy count, almost-full/empty thresholds, flush and sticky overflow error.
//  Decouples MIPS32 pipeline stages and bus producers/consumers of differing rates.
// PARAMETERS
//  WIDTH            32   data word width in bits
//  DEPTH            64   entries; power of 2, >= 2
//  ALMOST_FULL_TH   56   AlmostFull asserted when Count >= this (1..DEPTH)
//  ALMOST_EMPTY_TH  8    AlmostEmpty asserted when Count <= this (0..DEPTH-1)
// PORTS  (AW = $clog2(DEPTH))
//  Clock        in   1      clock; all state updates on rising edge
//  Reset        in   1      synchronous, active-high
//  Flush        in   1      synchronous discard of all contents
//  In_Data      in   WIDTH  write data
//  In_Valid     in   1      producer offers In_Data
//  In_Ready     out  1      FIFO can accept a word this cycle
//  Out_Data     out  WIDTH  head-of-queue word (FWFT)
//  Out_Valid    out  1      Out_Data holds a valid word
//  Out_Ready    in   1      consumer takes Out_Data this cycle
//  Count        out  AW+1   current occupancy, 0..DEPTH
//  AlmostFull   out  1      Count >= ALMOST_FULL_TH
//  AlmostEmpty  out  1      Count <= ALMOST_EMPTY_TH
//  Overflow     out  1      sticky: write attempted while full
// BEHAVIOUR
//  Interface: reset Reset, synchronous, active-high; clock Clock.
//  Reset: wr_ptr=rd_ptr=0, Count=0, state EMPTY, Overflow=0 -> In_Ready=1, Out_Valid=0,
//   AlmostEmpty=1, AlmostFull=0. Storage array not reset. Reset has priority over Flush.
//  FSM: EMPTY (Count=0), ACTIVE (0<Count<DEPTH), FULL (Count=DEPTH).
//   EMPTY->ACTIVE on write; ACTIVE->FULL on write-only at Count=DEPTH-1;
//   ACTIVE->EMPTY on read-only at Count=1; FULL->ACTIVE on read; any -> EMPTY on Flush.
//  wr_fire = In_Valid & In_Ready; rd_fire = Out_Valid & Out_Ready.
//  In_Ready = (state!=FULL); Out_Valid = (state!=EMPTY); both depend on registered state only,
//   never combinationally on In_Valid/Out_Ready.
//  wr_fire: mem[wr_ptr]<=In_Data, wr_ptr+1. rd_fire: rd_ptr+1. Pointers AW bits, wrap mod DEPTH.
//  Count: +1 write-only, -1 read-only, unchanged on both or neither; never exceeds DEPTH or < 0.
//  Out_Data = mem[rd_ptr] combinationally; value is don't-care while Out_Valid=0.
//  Latency: word written at edge N is visible (Out_Valid=1) in the cycle after edge N; no bypass.
//  Empty + In_Valid: write only, no same-cycle read. Full + Out_Ready: read only; In_Ready=0 so a
//   same-cycle write is refused even though a slot frees (no full-bypass).
//  Simultaneous read+write in ACTIVE: both fire, Count unchanged, data order preserved.
//  Overflow: set when In_Valid=1 and In_Ready=0; held until Reset or Flush. Data dropped.
//  Flush: next edge pointers/Count=0, Overflow=0, state EMPTY; wr/rd in the Flush cycle ignored.
//  AlmostFull/AlmostEmpty: combinational compares of registered Count.
//  Reset or Flush mid-burst: in-flight data lost; no partial state survives.
// TESTING
//  Reset, idle -> Count=0, Out_Valid=0, In_Ready=1, AlmostEmpty=1, AlmostFull=0, Overflow=0.
//  Write 0x1..0x40 with Out_Ready=0 -> Count=64, In_Ready=0, AlmostFull from Count=56 on;
//   65th In_Valid -> Overflow=1, Count stays 64; then drain -> 0x1..0x40 in order.
//  Single write 0xA5A5A5A5 to empty at edge N -> Out_Valid=1 and Out_Data=0xA5A5A5A5 after edge N.
//  Continuous In_Valid=Out_Ready=1 for 200 words at Count=3 -> Count stays 3, pointers wrap,
//   output sequence matches input with 3-word lag, no drop.
//  Full + Out_Ready=1 + In_Valid=1 -> one read, no write, Count=63, Overflow=1.
//  Count=20, Flush=1 with In_Valid=1 -> Count=0, Out_Valid=0, Overflow=0, write discarded.

Source files
------------

// File: rtl/fifo_ring_buffer.sv
// Circular-buffer FIFO, first-word-fall-through, valid/ready on both sides.
// Occupancy count, almost-full/empty flags, flush and sticky overflow.
module fifo_ring_buffer #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned ALMOST_FULL_TH  = 56,
    parameter int unsigned ALMOST_EMPTY_TH = 8,
    localparam int unsigned AW             = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Flush,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Out_Data,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [AW:0]      Count,
    output logic             AlmostFull,
    output logic             AlmostEmpty,
    output logic             Overflow
);

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_FULL   = 2'd2;

    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] AF_TH    = (AW+1)'(ALMOST_FULL_TH);
    localparam logic [AW:0] AE_TH    = (AW+1)'(ALMOST_EMPTY_TH);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             overflow_q;
    logic             wr_fire;
    logic             rd_fire;
    logic [WIDTH-1:0] mem [DEPTH];

    // Handshake outputs come from registered state only.
    assign In_Ready    = (state != S_FULL);
    assign Out_Valid   = (state != S_EMPTY);
    assign wr_fire     = In_Valid & In_Ready;
    assign rd_fire     = Out_Valid & Out_Ready;

    assign Out_Data    = mem[rd_ptr];
    assign Count       = count_q;
    assign AlmostFull  = (count_q >= AF_TH);
    assign AlmostEmpty = (count_q <= AE_TH);
    assign Overflow    = overflow_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_EMPTY: begin
                if (wr_fire)
                    state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (wr_fire && !rd_fire && count_q == CNT_LAST)
                    state_nxt = S_FULL;
                else if (rd_fire && !wr_fire && count_q == CNT_ONE)
                    state_nxt = S_EMPTY;
            end
            S_FULL: begin
                if (rd_fire)
                    state_nxt = S_ACTIVE;
            end
            default: state_nxt = S_EMPTY;
        endcase
        if (Flush)
            state_nxt = S_EMPTY;
    end

    always_ff @(posedge Clock) begin
        if (Reset || Flush) begin
            state      <= S_EMPTY;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr_fire)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_fire && !rd_fire)
                count_q <= count_q + 1'b1;
            else if (rd_fire && !wr_fire)
                count_q <= count_q - 1'b1;
            if (In_Valid && !In_Ready)
                overflow_q <= 1'b1;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge Clock) begin
        if (!Reset && !Flush && wr_fire)
            mem[wr_ptr] <= In_Data;
    end

endmodule
